// File: rtl/ibex_div_seq.sv
// ibex_div_seq: iterative 32-bit RISC-V divider (DIV/DIVU/REM/REMU).
// Each restoring step borrows the ALU's 33-bit adder for its trial subtraction.
// Sign handling, divide-by-zero and signed overflow are resolved here.
module ibex_div_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        div_en_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        kill_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        alu_sel_o,
  input  logic [33:0] alu_adder_ext_i
);

  // state | meaning
  // IDLE  | ready for a request
  // ITER  | 32 restoring steps through the shared ALU adder
  // FIX   | apply result sign and select quotient or remainder
  // DONE  | one-cycle valid strobe
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic        sign_a_q, sign_b_q;
  logic [31:0] b_abs_q, rem_q, quot_q, result_q;
  logic [4:0]  cnt_q;

  logic        signed_op, a_neg, b_neg, div_zero, sgn_ovf;
  logic [31:0] a_abs, b_abs, special_res;
  logic [31:0] shifted, rem_d, quot_d, fix_res;
  logic        msb, ok;
  logic        unused_ext;

  // Request decode: signed ops are DIV/REM (op bit 0 clear).
  always_comb begin
    signed_op   = ~div_op_i[0];
    a_neg       = signed_op & operand_a_i[31];
    b_neg       = signed_op & operand_b_i[31];
    a_abs       = a_neg ? (~operand_a_i + 32'd1) : operand_a_i;
    b_abs       = b_neg ? (~operand_b_i + 32'd1) : operand_b_i;
    div_zero    = (operand_b_i == 32'd0);
    sgn_ovf     = signed_op && (operand_a_i == 32'h8000_0000) &&
                  (operand_b_i == 32'hFFFF_FFFF);
    special_res = 32'd0;
    if (div_zero) special_res = div_op_i[1] ? operand_a_i : 32'hFFFF_FFFF;
    else          special_res = div_op_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step; the ALU computes shifted - |b| with carry-out in bit 33.
  always_comb begin
    shifted         = {rem_q[30:0], quot_q[31]};
    msb             = rem_q[31];
    alu_sel_o       = (state_q == ITER);
    alu_operand_a_o = alu_sel_o ? {shifted, 1'b1} : 33'd0;
    alu_operand_b_o = alu_sel_o ? {~b_abs_q, 1'b1} : 33'd0;
    ok              = msb | alu_adder_ext_i[33];
    rem_d           = ok ? alu_adder_ext_i[32:1] : shifted;
    quot_d          = {quot_q[30:0], ok};
    unused_ext      = alu_adder_ext_i[0];
  end

  // Final sign correction and quotient/remainder select.
  always_comb begin
    fix_res = quot_q;
    case (op_q)
      2'b00:   fix_res = (sign_a_q ^ sign_b_q) ? (~quot_q + 32'd1) : quot_q;
      2'b01:   fix_res = quot_q;
      2'b10:   fix_res = sign_a_q ? (~rem_q + 32'd1) : rem_q;
      default: fix_res = rem_q;
    endcase
  end

  // Sequencer: accept, iterate, fix up, strobe; kill aborts ITER/FIX only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_abs_q  <= 32'd0;
      rem_q    <= 32'd0;
      quot_q   <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_en_i && !kill_i) begin
            op_q     <= div_op_i;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            b_abs_q  <= b_abs;
            if (div_zero || sgn_ovf) begin
              result_q <= special_res;
              state_q  <= DONE;
            end else begin
              rem_q   <= 32'd0;
              quot_q  <= a_abs;
              cnt_q   <= 5'd0;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= FIX;
          end
        end
        FIX: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_res;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_div_seq.sv
// Directed bench for ibex_div_seq with a behavioural model of the ALU adder.
module tb_ibex_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_en = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] opa = 32'd0, opb = 32'd0;
  logic        kill = 1'b0;
  logic        ready, valid, alu_sel;
  logic [31:0] result;
  logic [32:0] alu_a, alu_b;
  logic [33:0] alu_ext;

  int nvec = 0;
  int nerr = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  always #5 clk = ~clk;

  // The ALU's extended adder: plain 34-bit sum of the two 33-bit operands.
  assign alu_ext = {1'b0, alu_a} + {1'b0, alu_b};

  ibex_div_seq dut (
    .clk_i(clk), .rst_i(rst), .div_en_i(div_en), .div_op_i(div_op),
    .operand_a_i(opa), .operand_b_i(opb), .kill_i(kill),
    .ready_o(ready), .valid_o(valid), .result_o(result),
    .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_adder_ext_i(alu_ext)
  );

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its strobe; all sampling on negedge.
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int sel_cnt;
    @(negedge clk);
    chk({tag, "_ready"}, {33'd0, ready}, 34'd1);
    div_en = 1'b1; div_op = op; opa = a; opb = b;
    @(negedge clk);
    div_en = 1'b0;
    lat = 1; sel_cnt = 0;
    while (!valid && lat < 100) begin
      if (alu_sel) sel_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {33'd0, valid}, 34'd1);
    chk({tag, "_latency"}, 34'(lat), 34'(exp_lat));
    chk({tag, "_result"}, {2'b0, result}, {2'b0, exp});
    chk({tag, "_selcnt"}, 34'(sel_cnt), (exp_lat == 34) ? 34'd32 : 34'd0);
    @(negedge clk);
    chk({tag, "_strobe_1cyc"}, {33'd0, valid}, 34'd0);
  endtask

  initial begin
    int nv;
    logic [31:0] cap;

    repeat (3) @(negedge clk);
    chk("rst_ready", {33'd0, ready}, 34'd1);
    chk("rst_valid", {33'd0, valid}, 34'd0);
    chk("rst_result", {2'b0, result}, 34'd0);
    chk("rst_sel", {33'd0, alu_sel}, 34'd0);
    chk("rst_alu_a", {1'b0, alu_a}, 34'd0);
    chk("rst_alu_b", {1'b0, alu_b}, 34'd0);
    rst = 1'b0;

    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run("remu_msb",   OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
    run("div_by0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_by0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // kill in IDLE wins over div_en: no accept, no strobe.
    @(negedge clk);
    kill = 1'b1; div_en = 1'b1; div_op = OP_DIV; opa = 32'd5; opb = 32'd0;
    @(negedge clk);
    kill = 1'b0; div_en = 1'b0;
    chk("idle_kill_ready", {33'd0, ready}, 34'd1);
    @(negedge clk);
    chk("idle_kill_novalid", {33'd0, valid}, 34'd0);
    chk("idle_kill_result", {2'b0, result}, 34'd0);

    // kill at ITER cycle 10.
    @(negedge clk);
    div_en = 1'b1; div_op = OP_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    div_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("kill_in_iter", {33'd0, alu_sel}, 34'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", {33'd0, ready}, 34'd1);
    chk("kill_valid", {33'd0, valid}, 34'd0);
    chk("kill_result", {2'b0, result}, 34'd0);
    chk("kill_sel", {33'd0, alu_sel}, 34'd0);
    chk("kill_alu_a", {1'b0, alu_a}, 34'd0);
    run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // div_en during a busy operation is ignored: exactly one strobe.
    @(negedge clk);
    div_en = 1'b1; div_op = OP_DIVU; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    div_en = 1'b0;
    repeat (5) @(negedge clk);
    div_en = 1'b1; div_op = OP_REMU; opa = 32'd50; opb = 32'd0;
    repeat (3) @(negedge clk);
    div_en = 1'b0;
    nv = 0; cap = 32'd0;
    for (int i = 0; i < 60; i++) begin
      if (valid) begin nv++; cap = result; end
      @(negedge clk);
    end
    chk("busy_one_valid", 34'(nv), 34'd1);
    chk("busy_result", {2'b0, cap}, 34'd14);

    // reset at ITER cycle 20.
    div_en = 1'b1; div_op = OP_DIV; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    div_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_in_iter", {33'd0, alu_sel}, 34'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", {33'd0, ready}, 34'd1);
    chk("mrst_valid", {33'd0, valid}, 34'd0);
    chk("mrst_result", {2'b0, result}, 34'd0);
    chk("mrst_sel", {33'd0, alu_sel}, 34'd0);
    chk("mrst_alu_a", {1'b0, alu_a}, 34'd0);
    chk("mrst_alu_b", {1'b0, alu_b}, 34'd0);
    repeat (40) begin
      @(negedge clk);
      if (valid) chk("mrst_no_strobe", {33'd0, valid}, 34'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ibex_div_seq.md
# ibex_div_seq

Iterative 32-bit RISC-V M-extension divider (DIV, DIVU, REM, REMU) that shares the ALU's 33-bit adder instead of owning one. It sits beside the ALU in the execute stage. On the iteration path it drives the ALU's multdiv operand and select inputs, and it consumes the ALU's extended adder result. Each of the 32 restoring-division steps uses one trial subtraction through that adder. Sign handling and RISC-V corner cases are resolved locally.

## Interface
Parameters:
- None. Data width is fixed at 32.

Ports:
- clk_i  in  1  Clock. Single clock domain.
- rst_i  in  1  Reset. Synchronous, active-high.
- div_en_i  in  1  Request valid. Sampled only when ready_o=1.
- div_op_i  in  2  Operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- operand_a_i  in  32  Dividend.
- operand_b_i  in  32  Divisor.
- kill_i  in  1  Abort the operation in flight.
- ready_o  out  1  High in IDLE.
- valid_o  out  1  One-cycle result strobe.
- result_o  out  32  Quotient or remainder. Held until the next accept.
- alu_operand_a_o  out  33  To the ALU multdiv operand A.
- alu_operand_b_o  out  33  To the ALU multdiv operand B.
- alu_sel_o  out  1  To the ALU multdiv select. High only in ITER.
- alu_adder_ext_i  in  34  Extended adder result from the ALU.

## Operation
State machine: IDLE, ITER, FIX, DONE.

IDLE
- ready_o=1.
- On div_en_i=1, latch the op, the sign flags, |a|, |b|, and the raw operand_a_i.
- If operand_b_i==0, or the op is DIV/REM with a=0x80000000 and b=0xFFFFFFFF, go to DONE with the special result.
- Otherwise clear rem and cnt, load quot with |a|, and go to ITER.

ITER (32 cycles; cnt counts 0..31)
- shifted = {rem[30:0], quot[31]}; msb = rem[31].
- alu_operand_a_o = {shifted, 1'b1}; alu_operand_b_o = {~|b|, 1'b1}. The ALU adder therefore computes shifted − |b| in bits [32:1], with the carry-out in bit 33.
- ok = msb | alu_adder_ext_i[33].
- rem ← ok ? alu_adder_ext_i[32:1] : shifted.
- quot ← {quot[30:0], ok}.
- After cnt==31, go to FIX.

FIX (1 cycle)
- DIV: result = sign_a^sign_b ? −quot : quot.
- DIVU: result = quot.
- REM: result = sign_a ? −rem : rem.
- REMU: result = rem.
- Register the result, then go to DONE.

DONE (1 cycle)
- valid_o=1; go to IDLE.

Special results
- Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the raw dividend.
- Signed overflow: DIV returns 0x80000000; REM returns 0.

Arithmetic
- |x| is computed as a 32-bit unsigned value, so |0x80000000| = 0x80000000.
- Unsigned ops take |x|=x.
- Negation is internal two's complement, modulo 2^32.

Boundary conditions
- div_en_i while ready_o=0 is ignored, not queued.
- kill_i in ITER or FIX moves the block to IDLE next cycle. No valid_o is produced and result_o keeps its old value.
- kill_i in DONE is ignored: the strobe still fires.
- kill_i in IDLE has priority over div_en_i: no accept.
- rst_i mid-operation has the same effect as kill_i, and also clears result_o.
- When alu_sel_o=0, alu_operand_a_o and alu_operand_b_o are driven to 0.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, alu_sel_o=0, alu_operand_a_o=0, alu_operand_b_o=0.
- Request accepted at the end of cycle N. ITER covers N+1..N+32, FIX is N+33, and valid_o=1 in N+34. Normal latency is 34 cycles.
- Special case: DONE in N+1, so valid_o=1 one cycle after accept.
- ready_o returns to 1 in the cycle after valid_o, so back-to-back issue is possible then.
- The ALU path is combinational within a cycle: operands are driven from the current registers and alu_adder_ext_i is sampled at the same edge.
- No registered outputs depend combinationally on div_en_i.

## Test plan
- DIVU 100/7 → valid_o exactly 34 cycles after accept, result 14. REMU same operands → 2. During ITER, alu_sel_o=1 for exactly 32 cycles.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; REMU 0xFFFFFFFF/0x80000001 → 0x7FFFFFFE. Both exercise the msb=1 path.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with valid_o one cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- kill_i at ITER cycle 10 → next cycle ready_o=1, no valid_o, result_o unchanged. A new DIVU 9/3 accepted immediately after → 3.
- rst_i asserted at ITER cycle 20 → next cycle: all outputs at reset values. div_en_i pulsed while busy → ignored; only one valid_o observed.
